// File: rtl/bus_decoder_if.sv
// bus_decoder_if: CPU-side bus and slave select/strobe/read-data bundle for bus_decoder.
// The decoder uses the slave modport; the CPU/peripheral side uses master.
interface bus_decoder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int NSLV   = 4
);
  logic [ADDR_W-1:0]      addr;
  logic                   we;
  logic                   rdy;
  logic [DATA_W-1:0]      cpu_dbr;
  logic [NSLV-1:0]        slv_sel;
  logic [NSLV-1:0]        slv_we;
  logic [NSLV*DATA_W-1:0] slv_dbr;

  modport slave (
    input  addr, we, slv_dbr,
    output rdy, cpu_dbr, slv_sel, slv_we
  );

  modport master (
    output addr, we, slv_dbr,
    input  rdy, cpu_dbr, slv_sel, slv_we
  );
endinterface

// File: rtl/bus_decoder.sv
// bus_decoder: 6502 system-bus address decoder, wait-state inserter and read-data mux.
// Define BUS_DECODE_ERR_EN to build the sticky unmapped-access capture (err_flag/err_addr).
//
// state | meaning
// IDLE  | decode a new access; complete it now or load the wait down-counter
// WAIT  | CPU stalled; access completes when the counter reaches terminal count 0
module bus_decoder #(
  parameter int                     ADDR_W   = 16,
  parameter int                     DATA_W   = 8,
  parameter int                     NSLV     = 4,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NSLV*ADDR_W-1:0] SLV_MASK = '1,
  parameter logic [NSLV*4-1:0]      SLV_WAIT = '0,
  parameter logic [DATA_W-1:0]      OPEN_BUS = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  bus_decoder_if.slave      bus,
  input  logic              err_clr,
  output logic              err_flag,
  output logic [ADDR_W-1:0] err_addr
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [NSLV-1:0]   hit, sel;
  logic [3:0]        wait_sel;
  logic              miss;
  logic              rdy_c;
  logic [NSLV-1:0]   cs_q;
  logic              miss_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] rd_mux;

  // Raw region match for every slave
  always_comb begin
    hit = '0;
    for (int i = 0; i < NSLV; i++) begin
      hit[i] = ((bus.addr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W]));
    end
  end

  // Priority select: scanning downward lets the lowest matching index win
  always_comb begin
    sel      = '0;
    wait_sel = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel      = '0;
        sel[i]   = 1'b1;
        wait_sel = SLV_WAIT[i*4 +: 4];
      end
    end
  end

  assign miss = ~|hit;

  // Wait-state FSM and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, down-counter and RDY; a miss has zero wait so it completes in IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_c   = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (wait_sel != 4'd0) begin
          rdy_c   = 1'b0;
          cnt_d   = wait_sel - 4'd1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          rdy_c = 1'b0;
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.rdy     = rdy_c;
  assign bus.slv_sel = sel;
  // Strobe only on the completing cycle, and never while reset is held
  assign bus.slv_we  = (bus.we && rdy_c && rst) ? sel : '0;

  // Data-phase capture of which source returns data on the following cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_q   <= '0;
      miss_q <= 1'b0;
      hold_q <= OPEN_BUS;
    end else begin
      cs_q   <= sel & {NSLV{rdy_c}};
      miss_q <= miss & rdy_c;
      if ((|cs_q) || miss_q) hold_q <= rd_mux;
    end
  end

  // Read-data mux; holds the last returned value between completions
  always_comb begin
    rd_mux = hold_q;
    if (miss_q) rd_mux = OPEN_BUS;
    for (int i = 0; i < NSLV; i++) begin
      if (cs_q[i]) rd_mux = bus.slv_dbr[i*DATA_W +: DATA_W];
    end
  end

  assign bus.cpu_dbr = rd_mux;

`ifdef BUS_DECODE_ERR_EN
  logic              err_flag_q;
  logic [ADDR_W-1:0] err_addr_q;

  // First unmapped completing access is captured; a clear in the same cycle lets a new miss re-arm
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_flag_q <= 1'b0;
      err_addr_q <= '0;
    end else if (miss && rdy_c && (!err_flag_q || err_clr)) begin
      err_flag_q <= 1'b1;
      err_addr_q <= bus.addr;
    end else if (err_clr) begin
      err_flag_q <= 1'b0;
      err_addr_q <= '0;
    end
  end

  assign err_flag = err_flag_q;
  assign err_addr = err_addr_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_flag       = 1'b0;
  assign err_addr       = '0;
`endif

endmodule

// File: tb/tb_bus_decoder.sv
// tb_bus_decoder: randomized and directed checks of bus_decoder against a region-table model.
`timescale 1ns/1ps
module tb_bus_decoder;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int NA = 3;
  localparam int NB = 2;
  localparam logic [NA*AW-1:0] BASE_A = {16'hFF00, 16'hFE20, 16'hFE00};
  localparam logic [NA*AW-1:0] MASK_A = {16'hFF00, 16'hFFE0, 16'hFFE0};
  localparam logic [NA*4-1:0]  WAIT_A = {4'd0, 4'd3, 4'd0};
  localparam logic [NB*AW-1:0] BASE_B = {16'hFE20, 16'hFE00};
  localparam logic [NB*AW-1:0] MASK_B = {16'hFFE0, 16'hFF00};
  localparam logic [NB*4-1:0]  WAIT_B = '0;
  localparam logic [15:0]      PARK   = 16'hFF00;

  // Region table for the model, written as the system memory map
  logic [15:0] m_base [NA] = '{16'hFE00, 16'hFE20, 16'hFF00};
  logic [15:0] m_mask [NA] = '{16'hFFE0, 16'hFFE0, 16'hFF00};
  int          m_wait [NA] = '{0, 3, 0};
  logic [15:0] o_base [NB] = '{16'hFE00, 16'hFE20};
  logic [15:0] o_mask [NB] = '{16'hFF00, 16'hFFE0};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        err_clr = 1'b0;
  logic        err_clr_b = 1'b0;
  logic        err_flag, err_flag_b;
  logic [15:0] err_addr, err_addr_b;
  logic [7:0]  sd [NA];
  bit          m_eflag;
  logic [15:0] m_eaddr;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  bus_decoder_if #(.ADDR_W(AW), .DATA_W(DW), .NSLV(NA)) bm ();
  bus_decoder_if #(.ADDR_W(AW), .DATA_W(DW), .NSLV(NB)) bo ();

  bus_decoder #(.ADDR_W(AW), .DATA_W(DW), .NSLV(NA), .SLV_BASE(BASE_A), .SLV_MASK(MASK_A),
                .SLV_WAIT(WAIT_A), .OPEN_BUS(8'hFF)) dut (
    .clk(clk), .rst(rst), .bus(bm.slave), .err_clr(err_clr),
    .err_flag(err_flag), .err_addr(err_addr));

  bus_decoder #(.ADDR_W(AW), .DATA_W(DW), .NSLV(NB), .SLV_BASE(BASE_B), .SLV_MASK(MASK_B),
                .SLV_WAIT(WAIT_B), .OPEN_BUS(8'hFF)) dut_ov (
    .clk(clk), .rst(rst), .bus(bo.slave), .err_clr(err_clr_b),
    .err_flag(err_flag_b), .err_addr(err_addr_b));

  function automatic int decode_a(input logic [15:0] a);
    for (int i = 0; i < NA; i++)
      if ((a & m_mask[i]) == (m_base[i] & m_mask[i])) return i;
    return -1;
  endfunction

  function automatic int decode_b(input logic [15:0] a);
    for (int i = 0; i < NB; i++)
      if ((a & o_mask[i]) == (o_base[i] & o_mask[i])) return i;
    return -1;
  endfunction

  task automatic set_data();
    for (int i = 0; i < NA; i++) sd[i] = 8'($urandom);
    bm.slv_dbr = {sd[2], sd[1], sd[0]};
  endtask

  // Runs one CPU access to completion and reports what was observed
  task automatic run_access(input logic [15:0] a, input logic w, output int stalls,
                            output int pulses, output logic [NA-1:0] sel_obs,
                            output logic [NA-1:0] we_done, output bit hold_ok,
                            output logic [7:0] rdata, output bit timeout);
    logic [7:0] first_hold;
    stalls = 0; pulses = 0; sel_obs = '0; we_done = '0; hold_ok = 1'b1;
    rdata = '0; timeout = 1'b1; first_hold = '0;
    bm.addr = a; bm.we = w;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) sel_obs = bm.slv_sel;
      if (bm.slv_we != '0) pulses++;
      if (bm.rdy) begin
        we_done = bm.slv_we;
        @(posedge clk); #1;
        rdata = bm.cpu_dbr;
        timeout = 1'b0;
        break;
      end
      if (stalls == 0) first_hold = bm.cpu_dbr;
      else if (bm.cpu_dbr !== first_hold) hold_ok = 1'b0;
      stalls++;
      @(posedge clk); #1;
    end
    bm.addr = PARK; bm.we = 1'b0;
  endtask

  // Full model comparison of one access on the main decoder
  task automatic check_model_access(input string tag, input logic [15:0] a, input logic w);
    int stl, pls, idx, est;
    logic [NA-1:0] sl, wd, es, ew;
    bit hok, to;
    logic [7:0] rd, erd;
    idx = decode_a(a);
    es = '0;
    if (idx >= 0) es[idx] = 1'b1;
    est = (idx >= 0) ? m_wait[idx] : 0;
    ew = w ? es : '0;
    erd = (idx >= 0) ? sd[idx] : 8'hFF;
    run_access(a, w, stl, pls, sl, wd, hok, rd, to);
    if (idx < 0 && (!m_eflag)) begin m_eflag = 1'b1; m_eaddr = a; end
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL %s timeout addr=%h", tag, a); end
    checks++; if (sl !== es) begin errors++; $display("FAIL %s sel addr=%h got %b exp %b", tag, a, sl, es); end
    checks++; if (stl != est) begin errors++; $display("FAIL %s stalls addr=%h got %0d exp %0d", tag, a, stl, est); end
    checks++; if (pls != (w && idx >= 0 ? 1 : 0) || wd !== ew) begin
      errors++; $display("FAIL %s strobe addr=%h pulses %0d done %b exp %b", tag, a, pls, wd, ew); end
    checks++; if (rd !== erd) begin errors++; $display("FAIL %s rdata addr=%h got %h exp %h", tag, a, rd, erd); end
    checks++; if (!hok) begin errors++; $display("FAIL %s hold addr=%h cpu_dbr moved during stall", tag, a); end
`ifdef BUS_DECODE_ERR_EN
    checks++; if (err_flag !== m_eflag || err_addr !== m_eaddr) begin
      errors++; $display("FAIL %s err got %b/%h exp %b/%h", tag, err_flag, err_addr, m_eflag, m_eaddr); end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b0; bm.addr = PARK; bm.we = 1'b1; bm.slv_dbr = '0;
    bo.addr = 16'hFE00; bo.we = 1'b0; bo.slv_dbr = '0;
    repeat (2) @(negedge clk);
    checks++; if (bm.cpu_dbr !== 8'hFF) begin errors++; $display("FAIL reset cpu_dbr got %h exp ff", bm.cpu_dbr); end
    checks++; if (bm.slv_we !== 3'b000) begin errors++; $display("FAIL reset slv_we got %b exp 000", bm.slv_we); end
    checks++; if (bm.slv_sel !== 3'b100 || bm.rdy !== 1'b1) begin
      errors++; $display("FAIL reset sel/rdy got %b/%b exp 100/1", bm.slv_sel, bm.rdy); end
    checks++; if (err_flag !== 1'b0 || err_addr !== 16'h0) begin
      errors++; $display("FAIL reset err got %b/%h exp 0/0000", err_flag, err_addr); end
    @(posedge clk); #1;
    bm.we = 1'b0; rst = 1'b1;
    m_eflag = 1'b0; m_eaddr = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_read();
    set_data();
    sd[2] = 8'hA5; bm.slv_dbr = {sd[2], sd[1], sd[0]};
    check_model_access("basic_read", 16'hFF10, 1'b0);
  endtask

  task automatic test_wait_write();
    check_model_access("wait_write", 16'hFE21, 1'b1);
  endtask

  task automatic test_miss();
    int stl, pls; logic [NA-1:0] sl, wd; bit hok, to; logic [7:0] rd;
    run_access(16'h1234, 1'b0, stl, pls, sl, wd, hok, rd, to);
    checks++; if (to || sl !== 3'b000 || stl != 0) begin
      errors++; $display("FAIL miss decode sel %b stalls %0d timeout %0d exp 000/0/0", sl, stl, to); end
    checks++; if (rd !== 8'hFF) begin errors++; $display("FAIL miss rdata got %h exp ff", rd); end
`ifdef BUS_DECODE_ERR_EN
    checks++; if (err_flag !== 1'b1 || err_addr !== 16'h1234) begin
      errors++; $display("FAIL miss err1 got %b/%h exp 1/1234", err_flag, err_addr); end
`else
    checks++; if (err_flag !== 1'b0 || err_addr !== 16'h0) begin
      errors++; $display("FAIL miss err1 got %b/%h exp 0/0000", err_flag, err_addr); end
`endif
    run_access(16'h2000, 1'b1, stl, pls, sl, wd, hok, rd, to);
    checks++; if (pls != 0 || wd !== 3'b000) begin
      errors++; $display("FAIL miss write_dropped pulses %0d done %b exp 0/000", pls, wd); end
`ifdef BUS_DECODE_ERR_EN
    checks++; if (err_flag !== 1'b1 || err_addr !== 16'h1234) begin
      errors++; $display("FAIL miss err2 got %b/%h exp 1/1234", err_flag, err_addr); end
`endif
  endtask

  task automatic test_err_clear();
    int stl, pls; logic [NA-1:0] sl, wd; bit hok, to; logic [7:0] rd;
    err_clr = 1'b1;
    run_access(16'h3000, 1'b0, stl, pls, sl, wd, hok, rd, to);
    err_clr = 1'b0;
`ifdef BUS_DECODE_ERR_EN
    checks++; if (err_flag !== 1'b1 || err_addr !== 16'h3000) begin
      errors++; $display("FAIL err_clear set_wins got %b/%h exp 1/3000", err_flag, err_addr); end
`else
    checks++; if (err_flag !== 1'b0 || err_addr !== 16'h0) begin
      errors++; $display("FAIL err_clear ignored got %b/%h exp 0/0000", err_flag, err_addr); end
`endif
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    checks++; if (err_flag !== 1'b0 || err_addr !== 16'h0) begin
      errors++; $display("FAIL err_clear cleared got %b/%h exp 0/0000", err_flag, err_addr); end
    m_eflag = 1'b0; m_eaddr = '0;
  endtask

  task automatic test_reset_mid_wait();
    int pls;
    pls = 0;
    bm.addr = 16'hFE21; bm.we = 1'b1;
    @(negedge clk);
    if (bm.slv_we != '0) pls++;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bm.slv_we != '0) pls++;
      checks++; if (bm.rdy !== 1'b0 || bm.cpu_dbr !== 8'hFF) begin
        errors++; $display("FAIL rst_mid_wait cycle %0d rdy %b cpu_dbr %h exp 0/ff", c, bm.rdy, bm.cpu_dbr); end
    end
    checks++; if (pls != 0) begin errors++; $display("FAIL rst_mid_wait strobe pulses %0d exp 0", pls); end
    @(posedge clk); #1;
    rst = 1'b1;
    m_eflag = 1'b0; m_eaddr = '0;
    check_model_access("rst_mid_wait_retry", 16'hFE21, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [15:0] al [6] = '{16'hFE21, 16'hFE3F, 16'hFE00, 16'hFE20, 16'hFFFF, 16'hFE1F};
    logic        wl [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    set_data();
    for (int i = 0; i < 6; i++) check_model_access("back_to_back", al[i], wl[i]);
  endtask

  task automatic test_overlap();
    logic [15:0] al [6] = '{16'hFE25, 16'hFE05, 16'hFF00, 16'hFE3F, 16'hFE40, 16'h0000};
    logic [15:0] a;
    logic [NB-1:0] es;
    int idx;
    for (int i = 0; i < 26; i++) begin
      a = (i < 6) ? al[i] : 16'($urandom);
      @(posedge clk); #1;
      bo.addr = a;
      @(negedge clk);
      idx = decode_b(a);
      es = '0;
      if (idx >= 0) es[idx] = 1'b1;
      checks++; if (bo.slv_sel !== es || bo.rdy !== 1'b1) begin
        errors++; $display("FAIL overlap addr=%h sel %b rdy %b exp %b/1", a, bo.slv_sel, bo.rdy, es); end
    end
`ifdef BUS_DECODE_ERR_EN
    checks++; if (err_flag_b !== 1'b1 || err_addr_b !== 16'hFF00) begin
      errors++; $display("FAIL overlap err got %b/%h exp 1/ff00", err_flag_b, err_addr_b); end
`else
    checks++; if (err_flag_b !== 1'b0 || err_addr_b !== 16'h0) begin
      errors++; $display("FAIL overlap err got %b/%h exp 0/0000", err_flag_b, err_addr_b); end
`endif
  endtask

  task automatic test_random();
    logic [15:0] a;
    for (int i = 0; i < 60; i++) begin
      if (i % 8 == 0) set_data();
      case ($urandom_range(0, 3))
        0:       a = 16'hFE00 + 16'($urandom_range(0, 63));
        1:       a = 16'hFF00 | 16'($urandom_range(0, 255));
        default: a = 16'($urandom);
      endcase
      check_model_access("random", a, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_read();
    test_wait_write();
    test_miss();
    test_err_clear();
    test_reset_mid_wait();
    test_back_to_back();
    test_overlap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
